// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch FIFO between the PC/IM fetch path and ID.
// Captures {pc, instr} pairs, holds the PC when full, drops all entries on flush.
// Optional FB_EXC_EN: tag each entry with a fetch-fault bit (misaligned or
// outside [IM_BASE, IM_LIMIT]) and replace faulting instructions with a nop.
//
// Handshake: the upstream side pushes when in_valid & pc_en (pc_en depends only
// on occupancy, never on in_valid or out_ready); the downstream side pops when
// out_valid & out_ready. flush suppresses both in the same cycle.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] IM_BASE  = 32'h00003000,
  parameter logic [31:0] IM_LIMIT = 32'h00006FFC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     pc_en,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc8,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     out_exc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Elaboration guard: pointer wrap relies on a power-of-2 depth.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (IM_BASE > IM_LIMIT)) begin : g_bad_cfg
    $error("fetch_buffer: invalid DEPTH or IM_BASE/IM_LIMIT");
  end

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   pc_mem_d    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic          push;
  logic          pop;
  logic [31:0]   wr_instr;
  logic          head_exc;

`ifdef FB_EXC_EN
  logic exc_mem_q [DEPTH];
  logic exc_mem_d [DEPTH];
  logic in_fault;

  assign in_fault = (in_pc[1:0] != 2'b00) | (in_pc < IM_BASE) | (in_pc > IM_LIMIT);
  assign wr_instr = in_fault ? 32'h0 : in_instr;
  assign head_exc = exc_mem_q[rd_ptr_q];
`else
  assign wr_instr = in_instr;
  assign head_exc = 1'b0;
`endif

  assign pc_en     = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & pc_en & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  // Head entry presentation; zeros (nop) whenever the buffer is empty.
  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    out_pc8   = '0;
    out_exc   = 1'b0;
    if (out_valid) begin
      out_pc    = pc_mem_q[rd_ptr_q];
      out_instr = instr_mem_q[rd_ptr_q];
      out_pc8   = pc_mem_q[rd_ptr_q] + 32'd8;
      out_exc   = head_exc;
    end
  end

  // Pointer and occupancy next-state; flush empties the buffer outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Entry write: store the fetched pair at the write pointer on a push.
  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
`ifdef FB_EXC_EN
    exc_mem_d   = exc_mem_q;
`endif
    if (push) begin
      pc_mem_d[wr_ptr_q]    = in_pc;
      instr_mem_d[wr_ptr_q] = wr_instr;
`ifdef FB_EXC_EN
      exc_mem_d[wr_ptr_q]   = in_fault;
`endif
    end
  end

  // Control state register; reset outranks flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
`ifdef FB_EXC_EN
    exc_mem_q   <= exc_mem_d;
`endif
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed plus short random stimulus for fetch_buffer,
// checked every cycle against a queue model of the FIFO.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] IM_BASE  = 32'h00003000;
  localparam logic [31:0] IM_LIMIT = 32'h00006FFC;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        pc_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc8;
  logic [2:0]  count;
  logic        out_exc;

  int nvec = 0;
  int nmis = 0;
  bit chk_en = 0;

  // Model entries packed as {exc, pc, instr}.
  logic [64:0] exp_q[$];

  fetch_buffer #(.DEPTH(DEPTH), .IM_BASE(IM_BASE), .IM_LIMIT(IM_LIMIT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .pc_en(pc_en), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_pc8(out_pc8), .count(count), .out_exc(out_exc)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_fault(input logic [31:0] pc);
`ifdef FB_EXC_EN
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
`else
    return 1'b0;
`endif
  endfunction

  // Model: a plain queue of accepted fetches, updated on each clock edge.
  always @(posedge clk) begin
    bit can_push, can_pop;
    logic f;
    can_push = in_valid && (exp_q.size() != DEPTH) && !flush;
    can_pop  = (exp_q.size() != 0) && out_ready && !flush;
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (can_pop) void'(exp_q.pop_front());
      if (can_push) begin
        f = model_fault(in_pc);
        exp_q.push_back({f, in_pc, f ? 32'h0 : in_instr});
      end
    end
  end

  // Compare process: every outputs-valid cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [64:0] h;
      bit v;
      v = (exp_q.size() != 0);
      h = v ? exp_q[0] : 65'h0;
      chk("out_valid", {31'h0, out_valid}, {31'h0, v});
      chk("count", {29'h0, count}, exp_q.size());
      chk("pc_en", {31'h0, pc_en}, {31'h0, exp_q.size() != DEPTH});
      chk("out_pc", out_pc, h[63:32]);
      chk("out_instr", out_instr, h[31:0]);
      chk("out_pc8", out_pc8, v ? h[63:32] + 32'd8 : 32'h0);
      chk("out_exc", {31'h0, out_exc}, {31'h0, h[64]});
    end
  end

  // Driver: apply one cycle of inputs, return just after the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl);
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    reset = 1'b0;

    // Reset then idle
    step(0, 32'h0, 32'h0, 0, 0);
    chk("t1_count", {29'h0, count}, 32'd0);
    chk("t1_valid", {31'h0, out_valid}, 32'd0);
    chk("t1_pc", out_pc, 32'h0);
    chk("t1_instr", out_instr, 32'h0);
    chk("t1_pc_en", {31'h0, pc_en}, 32'd1);

    // Single push, visible next cycle
    step(1, 32'h3000, 32'h24010001, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    chk("t2_valid", {31'h0, out_valid}, 32'd1);
    chk("t2_pc", out_pc, 32'h3000);
    chk("t2_pc8", out_pc8, 32'h3008);
    chk("t2_instr", out_instr, 32'h24010001);
    chk("t2_count", {29'h0, count}, 32'd1);

    // Fill to full, fifth fetch held off
    step(0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'h3000 + 32'(4 * i), 32'h100 + 32'(i), 0, 0);
    chk("t3_count", {29'h0, count}, 32'd4);
    chk("t3_pc_en", {31'h0, pc_en}, 32'd0);
    step(1, 32'h3010, 32'h104, 0, 0);
    chk("t3_count_hold", {29'h0, count}, 32'd4);
    chk("t3_head", out_pc, 32'h3000);

    // Full with pop: pop only, then push+pop steady state
    step(1, 32'h3010, 32'h104, 1, 0);
    chk("t4_count", {29'h0, count}, 32'd3);
    chk("t4_pc_en", {31'h0, pc_en}, 32'd1);
    chk("t4_head", out_pc, 32'h3004);
    step(1, 32'h3010, 32'h104, 1, 0);
    chk("t4_count_pp", {29'h0, count}, 32'd3);
    chk("t4_head2", out_pc, 32'h3008);
    step(1, 32'h3014, 32'h105, 1, 0);
    chk("t4_count_pp2", {29'h0, count}, 32'd3);

    // Flush beats push and pop
    step(1, 32'h3018, 32'h106, 1, 1);
    chk("t5_count", {29'h0, count}, 32'd0);
    chk("t5_valid", {31'h0, out_valid}, 32'd0);
    step(1, 32'h4000, 32'h200, 0, 0);
    chk("t5_head", out_pc, 32'h4000);
    chk("t5_count1", {29'h0, count}, 32'd1);

    // Push+pop at count 1, then pop attempts on empty
    step(1, 32'h4004, 32'h201, 1, 0);
    chk("b_count1", {29'h0, count}, 32'd1);
    chk("b_head", out_pc, 32'h4004);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("b_empty", {29'h0, count}, 32'd0);

    // pc+8 wraps modulo 2^32
    step(1, 32'hFFFFFFFC, 32'h300, 0, 0);
    chk("b_pc8_wrap", out_pc8, 32'h00000004);
    step(0, 32'h0, 32'h0, 0, 1);

`ifdef FB_EXC_EN
    step(1, 32'h3002, 32'h11111111, 0, 0);
    step(1, 32'h7000, 32'h22222222, 0, 0);
    step(1, 32'h3004, 32'h33333333, 0, 0);
    chk("t6_exc0", {31'h0, out_exc}, 32'd1);
    chk("t6_instr0", out_instr, 32'h0);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("t6_exc1", {31'h0, out_exc}, 32'd1);
    chk("t6_pc1", out_pc, 32'h7000);
    chk("t6_instr1", out_instr, 32'h0);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("t6_exc2", {31'h0, out_exc}, 32'd0);
    chk("t6_instr2", out_instr, 32'h33333333);
    step(0, 32'h0, 32'h0, 0, 1);
`endif

    // Random traffic with occasional flush and stray addresses
    for (int i = 0; i < 300; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? $urandom() : 32'h3000 + 32'(4 * $urandom_range(0, 4095));
      step(1'($urandom_range(0, 3) != 0), pc, $urandom(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 32'h5000 + 32'(4 * i), 32'h400, 0, 0);
    reset = 1'b1;
    step(1, 32'h500C, 32'h401, 1, 1);
    reset = 1'b0;
    chk("rst_count", {29'h0, count}, 32'd0);
    chk("rst_pc_en", {31'h0, pc_en}, 32'd1);
    chk("rst_pc", out_pc, 32'h0);
    step(0, 32'h0, 32'h0, 0, 0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
